// File: rtl/perf_cnt_unit.sv
// rtl/perf_cnt_unit.sv - run-time bindable performance-counter bank with lo/hi decimal-friendly words
// Optional shadow snapshot outputs enabled by defining PERF_CNT_SNAPSHOT_EN.
module perf_cnt_unit #(
    parameter int          NUM_CNT   = 10,
    parameter int          NUM_EVT   = 16,
    parameter int          EVT_SEL_W = 4,
    parameter int          IDX_W     = 4,
    parameter int          W         = 32,
    parameter logic [W-1:0] LOW_MAX  = W'(999999999)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_EVT-1:0]     evt,
    input  logic                   cfg_wen,
    input  logic [IDX_W-1:0]       cfg_idx,
    input  logic [EVT_SEL_W+1:0]   cfg_wdata,
    input  logic                   global_freeze,
    input  logic                   global_clear,
    input  logic                   snap,
    output logic [NUM_CNT*W-1:0]   cnt_lo,
    output logic [NUM_CNT*W-1:0]   cnt_hi,
    output logic [NUM_CNT-1:0]     ovf
);

    logic                 wr_clr;
    logic                 wr_en;
    logic [EVT_SEL_W-1:0] wr_sel;

    always_comb begin
        wr_clr = cfg_wdata[EVT_SEL_W+1];
        wr_en  = cfg_wdata[EVT_SEL_W];
        wr_sel = cfg_wdata[EVT_SEL_W-1:0];
    end

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        logic [EVT_SEL_W-1:0] sel;
        logic                 en;
        logic [W-1:0]         lo;
        logic [W-1:0]         hi;
        logic                 ovf_r;
        logic                 hit;
        logic                 inc;
        logic                 wr;

        // Selects beyond the populated event lines read as a quiet event.
        always_comb begin
            hit = (32'(sel) < NUM_EVT) ? evt[sel] : 1'b0;
            inc = en && !global_freeze && hit;
            wr  = cfg_wen && (cfg_idx == IDX_W'(i));
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sel   <= '0;
                en    <= 1'b0;
                lo    <= '0;
                hi    <= '0;
                ovf_r <= 1'b0;
            end else begin
                if (wr) begin
                    sel <= wr_sel;
                    en  <= wr_en;
                end
                if (global_clear || (wr && wr_clr)) begin
                    lo    <= '0;
                    hi    <= '0;
                    ovf_r <= 1'b0;
                end else if (inc) begin
                    if (lo == LOW_MAX) begin
                        lo <= '0;
                        hi <= hi + 1'b1;
                        if (&hi) ovf_r <= 1'b1;
                    end else begin
                        lo <= lo + 1'b1;
                    end
                end
            end
        end

`ifdef PERF_CNT_SNAPSHOT_EN
        logic [W-1:0] lo_s;
        logic [W-1:0] hi_s;
        logic         ovf_s;

        // Shadows capture pre-edge values; global_clear deliberately leaves them alone.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lo_s  <= '0;
                hi_s  <= '0;
                ovf_s <= 1'b0;
            end else if (snap) begin
                lo_s  <= lo;
                hi_s  <= hi;
                ovf_s <= ovf_r;
            end
        end

        assign cnt_lo[i*W +: W] = lo_s;
        assign cnt_hi[i*W +: W] = hi_s;
        assign ovf[i]           = ovf_s;
`else
        assign cnt_lo[i*W +: W] = lo;
        assign cnt_hi[i*W +: W] = hi;
        assign ovf[i]           = ovf_r;
`endif
    end

`ifndef PERF_CNT_SNAPSHOT_EN
    logic snap_unused;
    assign snap_unused = snap;
`endif

endmodule

// File: tb/tb_perf_cnt_unit.sv
// tb/tb_perf_cnt_unit.sv - directed self-checking bench for perf_cnt_unit (small LOW_MAX/W for reachable wraps)
module tb_perf_cnt_unit;

    localparam int NC = 10;
    localparam int NE = 12;
    localparam int SW = 4;
    localparam int IW = 4;
    localparam int WW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NE-1:0]     evt;
    logic              cfg_wen;
    logic [IW-1:0]     cfg_idx;
    logic [SW+1:0]     cfg_wdata;
    logic              global_freeze;
    logic              global_clear;
    logic              snap;
    logic [NC*WW-1:0]  cnt_lo;
    logic [NC*WW-1:0]  cnt_hi;
    logic [NC-1:0]     ovf;

    int total  = 0;
    int passed = 0;

    perf_cnt_unit #(
        .NUM_CNT(NC), .NUM_EVT(NE), .EVT_SEL_W(SW), .IDX_W(IW), .W(WW), .LOW_MAX(4'd9)
    ) dut (
        .clk(clk), .rst(rst), .evt(evt), .cfg_wen(cfg_wen), .cfg_idx(cfg_idx),
        .cfg_wdata(cfg_wdata), .global_freeze(global_freeze), .global_clear(global_clear),
        .snap(snap), .cnt_lo(cnt_lo), .cnt_hi(cnt_hi), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lo(input int i);
        return 32'(cnt_lo[i*WW +: WW]);
    endfunction

    function automatic logic [31:0] hi(input int i);
        return 32'(cnt_hi[i*WW +: WW]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cfg(input int idx, input logic clr, input logic en, input int sel);
        cfg_wen   = 1'b1;
        cfg_idx   = IW'(idx);
        cfg_wdata = {clr, en, SW'(sel)};
        tick();
        cfg_wen   = 1'b0;
    endtask

    // In the snapshot build, refresh the shadows with a quiet cycle so live values become visible.
    task automatic sync_view();
`ifdef PERF_CNT_SNAPSHOT_EN
        logic [NE-1:0] e;
        e    = evt;
        evt  = '0;
        snap = 1'b1;
        tick();
        snap = 1'b0;
        evt  = e;
`endif
    endtask

    initial begin
        rst = 1'b1; evt = '0; cfg_wen = 1'b0; cfg_idx = '0; cfg_wdata = '0;
        global_freeze = 1'b0; global_clear = 1'b0; snap = 1'b0;
        ticks(2);
        chk("reset_lo", 32'(cnt_lo), 32'd0);
        chk("reset_hi", 32'(cnt_hi), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        // Counter 0 on event 0, five events.
        cfg(0, 1'b0, 1'b1, 0);
        evt = 12'h001;
        ticks(5);
        evt = '0;
        sync_view();
        chk("c0_lo5", lo(0), 5);
        chk("c0_hi0", hi(0), 0);
        chk("c1_idle", lo(1), 0);
        chk("c9_idle", lo(9), 0);

        // Counter 1 low wrap and high wrap.
        cfg(0, 1'b0, 1'b0, 0);
        cfg(1, 1'b0, 1'b1, 0);
        evt = 12'h001;
        ticks(8);
        sync_view();
        chk("c1_lo8", lo(1), 8);
        tick();
        sync_view();
        chk("c1_lo_max", lo(1), 9);
        tick();
        sync_view();
        chk("c1_carry_lo", lo(1), 0);
        chk("c1_carry_hi", hi(1), 1);
        ticks(149);
        sync_view();
        chk("c1_top_lo", lo(1), 9);
        chk("c1_top_hi", hi(1), 15);
        chk("c1_top_ovf", 32'(ovf[1]), 0);
        tick();
        sync_view();
        chk("c1_wrap_lo", lo(1), 0);
        chk("c1_wrap_hi", hi(1), 0);
        chk("c1_ovf_set", 32'(ovf[1]), 1);
        ticks(3);
        sync_view();
        chk("c1_after_lo", lo(1), 3);
        chk("c1_ovf_sticky", 32'(ovf[1]), 1);
        chk("c0_disabled", lo(0), 5);

        // Freeze with event held high.
        global_freeze = 1'b1;
        ticks(3);
        sync_view();
        chk("freeze_hold", lo(1), 3);
        global_freeze = 1'b0;
        tick();
        sync_view();
        chk("freeze_release", lo(1), 4);
        evt = '0;

        // Per-counter clear beats a same-cycle event.
        cfg(2, 1'b0, 1'b1, 1);
        evt = 12'h002;
        ticks(3);
        sync_view();
        chk("c2_lo3", lo(2), 3);
        cfg(2, 1'b1, 1'b1, 1);
        sync_view();
        chk("c2_clear_wins", lo(2), 0);
        tick();
        sync_view();
        chk("c2_en_kept", lo(2), 1);
        chk("c1_ovf_before_gclr", 32'(ovf[1]), 1);

        // Global clear together with a config clear and all events.
        evt = 12'hFFF;
        global_clear = 1'b1;
        cfg(3, 1'b1, 1'b1, 2);
        global_clear = 1'b0;
        sync_view();
        chk("gclr_lo1", lo(1), 0);
        chk("gclr_ovf", 32'(ovf), 0);
        chk("gclr_lo2", lo(2), 0);
        chk("gclr_lo0", lo(0), 0);
        evt = 12'hFFF;
        tick();
        sync_view();
        chk("post_gclr_c1", lo(1), 1);
        chk("post_gclr_c2", lo(2), 1);
        chk("post_gclr_c3", lo(3), 1);
        chk("post_gclr_c0", lo(0), 0);

        // Out-of-range event select and out-of-range counter index.
        evt = '0;
        cfg(4, 1'b0, 1'b1, 15);
        evt = 12'hFFF;
        ticks(3);
        evt = '0;
        sync_view();
        chk("sel15_quiet", lo(4), 0);
        chk("sel_c3", lo(3), 4);
        cfg(12, 1'b0, 1'b1, 0);
        evt = 12'h001;
        tick();
        evt = '0;
        sync_view();
        chk("idx12_c0", lo(0), 0);
        chk("idx12_c1", lo(1), 5);
        chk("idx12_hi_c5_9", 32'(cnt_lo[NC*WW-1:5*WW]), 0);

        // Snapshot behaviour: 7 events, snap, 3 more.
        cfg(5, 1'b0, 1'b1, 3);
        evt = 12'h008;
        ticks(7);
        evt = '0;
        snap = 1'b1;
        tick();
        snap = 1'b0;
        chk("snap_first", lo(5), 7);
        evt = 12'h008;
        ticks(3);
        evt = '0;
`ifdef PERF_CNT_SNAPSHOT_EN
        chk("snap_hold", lo(5), 7);
        snap = 1'b1;
        tick();
        snap = 1'b0;
`endif
        chk("snap_second", lo(5), 10 % 10);
        chk("snap_second_hi", hi(5), 1);

        // Asynchronous reset mid-count, then re-enable.
        evt = 12'h009;
        tick();
        rst = 1'b1;
        #1;
        chk("async_rst_lo", 32'(cnt_lo), 0);
        chk("async_rst_hi", 32'(cnt_hi), 0);
        tick();
        rst = 1'b0;
        ticks(2);
        sync_view();
        chk("rst_disabled", lo(5), 0);
        cfg(5, 1'b0, 1'b1, 3);
        evt = 12'h008;
        sync_view();
        chk("cfg_same_cycle_old_en", lo(5), 0);
        tick();
        sync_view();
        chk("reenabled", lo(5), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
